// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch-side branch/exception redirect controller.
package branch_redirect_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    WAIT_DS = 1'b1
  } redirect_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  localparam logic FlushEnable  = 1'b1;
  localparam logic FlushDisable = 1'b0;

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// EXE resolve / exception / IF fetch-request bundle seen by the redirect controller.
interface branch_redirect_ctrl_if;
  logic        EXE_Resolve;
  logic        EXE_Branch_Flush;
  logic        EXE_Delayslot_Flush;
  logic [31:0] EXE_PC;
  logic [31:0] EXE_Target;
  logic        DS_Fetched;
  logic        EXC_Flush;
  logic [31:0] EXC_Target;
  logic        IF_Ready;
  logic        IF_Valid;
  logic [31:0] IF_PC;
  logic        IF_Flush;
  logic        DS_Kill;
  logic        Redirect_Busy;

  // master: the redirect controller itself
  modport master (
    input  EXE_Resolve, EXE_Branch_Flush, EXE_Delayslot_Flush, EXE_PC, EXE_Target,
           DS_Fetched, EXC_Flush, EXC_Target, IF_Ready,
    output IF_Valid, IF_PC, IF_Flush, DS_Kill, Redirect_Busy
  );

  modport slave (
    output EXE_Resolve, EXE_Branch_Flush, EXE_Delayslot_Flush, EXE_PC, EXE_Target,
           DS_Fetched, EXC_Flush, EXC_Target, IF_Ready,
    input  IF_Valid, IF_PC, IF_Flush, DS_Kill, Redirect_Busy
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Owns the fetch PC; converts EXE branch resolution and exception pulses into fetch
// redirects, making sure a taken branch's delay slot is fetched exactly once first.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetn,
  branch_redirect_ctrl_if.master bus
);

  redirect_state_e state, state_nxt;
  logic [31:0]     pc, pc_nxt;
  logic [31:0]     pend_target, pend_nxt;
  logic            if_valid, if_flush, ds_kill;
  logic            taken, likely_nt;

  assign taken     = bus.EXE_Resolve & bus.EXE_Branch_Flush;
  assign likely_nt = bus.EXE_Resolve & bus.EXE_Delayslot_Flush & ~bus.EXE_Branch_Flush;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_nxt  = pend_target;
    if_valid  = 1'b1;
    if_flush  = FlushDisable;
    ds_kill   = 1'b0;
    if (bus.EXC_Flush) begin
      if_valid  = 1'b0;
      if_flush  = FlushEnable;
      pc_nxt    = bus.EXC_Target;
      pend_nxt  = '0;
      state_nxt = RUN;
    end else if (state == WAIT_DS) begin
      // Resolves are ignored here: Redirect_Busy is holding EXE.
      if (bus.IF_Ready) begin
        pc_nxt    = pend_target;
        state_nxt = RUN;
      end
    end else if (taken) begin
      if (bus.DS_Fetched) begin
        if_valid = 1'b0;
        if_flush = FlushEnable;
        pc_nxt   = bus.EXE_Target;
      end else if (bus.IF_Ready) begin
        // Delay slot is being accepted right now, so redirect immediately.
        pc_nxt = bus.EXE_Target;
      end else begin
        pend_nxt  = bus.EXE_Target;
        state_nxt = WAIT_DS;
      end
    end else if (likely_nt) begin
      if (bus.DS_Fetched) begin
        ds_kill = 1'b1;
        if (bus.IF_Ready) pc_nxt = pc + 32'd4;
      end else begin
        if_valid = 1'b0;
        pc_nxt   = bus.EXE_PC + 32'd8;
      end
    end else if (bus.IF_Ready) begin
      pc_nxt = pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= RUN;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pc <= RESET_PC;
    else         pc <= pc_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pend_target <= '0;
    else         pend_target <= pend_nxt;
  end

  assign bus.IF_Valid      = if_valid;
  assign bus.IF_PC         = pc;
  assign bus.IF_Flush      = if_flush;
  assign bus.DS_Kill       = ds_kill;
  assign bus.Redirect_Busy = (state == WAIT_DS);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_branch_redirect_ctrl;
  import branch_redirect_ctrl_pkg::*;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  branch_redirect_ctrl_if bus();

  branch_redirect_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model: fetch PC plus a queue holding at most one deferred redirect target.
  logic [31:0] m_pc;
  logic [31:0] pend_q[$];

  // Outputs as sampled in the most recent cycle, for literal checks.
  logic s_valid, s_flush, s_kill, s_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.EXE_Resolve = 0; bus.EXE_Branch_Flush = 0; bus.EXE_Delayslot_Flush = 0;
    bus.EXE_PC = '0; bus.EXE_Target = '0; bus.DS_Fetched = 0;
    bus.EXC_Flush = 0; bus.EXC_Target = '0; bus.IF_Ready = 0;
  endtask

  // One clock cycle: entered just after a negedge, leaves just after the next negedge.
  task automatic cycle(input bit rs, input bit bf, input bit df, input bit dsf,
                       input bit exc, input bit rdy,
                       input logic [31:0] epc, input logic [31:0] etgt, input logic [31:0] xtgt);
    bit e_valid, e_flush, e_kill, e_busy;
    logic [31:0] nxt;
    bus.EXE_Resolve = rs; bus.EXE_Branch_Flush = bf; bus.EXE_Delayslot_Flush = df;
    bus.EXE_PC = epc; bus.EXE_Target = etgt; bus.DS_Fetched = dsf;
    bus.EXC_Flush = exc; bus.EXC_Target = xtgt; bus.IF_Ready = rdy;
    #1;
    e_busy  = (pend_q.size() != 0);
    e_valid = 1; e_flush = 0; e_kill = 0;
    nxt = rdy ? m_pc + 32'd4 : m_pc;
    if (exc) begin
      e_valid = 0; e_flush = 1; nxt = xtgt;
      pend_q.delete();
    end else if (pend_q.size() != 0) begin
      // delay slot is on the bus; redirect once it is accepted
      nxt = rdy ? pend_q.pop_front() : m_pc;
    end else if (rs && bf) begin
      if (dsf) begin
        e_valid = 0; e_flush = 1; nxt = etgt;
      end else if (rdy) begin
        nxt = etgt;
      end else begin
        pend_q.push_back(etgt);
        nxt = m_pc;
      end
    end else if (rs && df) begin
      if (dsf) e_kill = 1;
      else begin e_valid = 0; nxt = epc + 32'd8; end
    end
    s_valid = bus.IF_Valid; s_flush = bus.IF_Flush; s_kill = bus.DS_Kill; s_busy = bus.Redirect_Busy;
    chk("if_pc",    bus.IF_PC,                 m_pc);
    chk("if_valid", {31'd0, bus.IF_Valid},      {31'd0, e_valid});
    chk("if_flush", {31'd0, bus.IF_Flush},      {31'd0, e_flush});
    chk("ds_kill",  {31'd0, bus.DS_Kill},       {31'd0, e_kill});
    chk("busy",     {31'd0, bus.Redirect_Busy}, {31'd0, e_busy});
    @(posedge clk);
    m_pc = nxt;
    @(negedge clk);
  endtask

  task automatic seq(input bit rdy);
    cycle(0, 0, 0, 0, 0, rdy, '0, '0, '0);
  endtask

  initial begin
    drive_idle();
    m_pc = RST_PC;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("reset_pc",    bus.IF_PC, 32'hBFC0_0000);
    chk("reset_valid", {31'd0, bus.IF_Valid}, 32'd1);
    chk("reset_busy",  {31'd0, bus.Redirect_Busy}, 32'd0);
    @(negedge clk);

    // Sequential fetch after reset
    seq(1); chk("seq1", bus.IF_PC, 32'hBFC0_0004);
    seq(1); chk("seq2", bus.IF_PC, 32'hBFC0_0008);
    seq(1); chk("seq3", bus.IF_PC, 32'hBFC0_000C);

    // Taken, delay slot already fetched
    cycle(1, 1, 0, 1, 0, 1, 32'h8000_0100, 32'h8000_0400, '0);
    chk("taken_flush", {31'd0, s_flush}, 32'd1);
    chk("taken_valid", {31'd0, s_valid}, 32'd0);
    chk("taken_pc", bus.IF_PC, 32'h8000_0400);

    // Move to 80000104, then taken with delay slot not yet fetched
    cycle(1, 1, 0, 1, 0, 1, 32'h8000_03FC, 32'h8000_0104, '0);
    cycle(1, 1, 0, 0, 0, 0, 32'h8000_0100, 32'h8000_0400, '0);
    repeat (3) begin
      seq(0);
      chk("wait_pc", bus.IF_PC, 32'h8000_0104);
      chk("wait_busy", {31'd0, s_busy}, 32'd1);
    end
    seq(1);
    chk("wait_done_pc", bus.IF_PC, 32'h8000_0400);
    chk("wait_done_busy", {31'd0, bus.Redirect_Busy}, 32'd0);

    // Likely-not-taken
    cycle(1, 0, 1, 1, 0, 1, 32'h8000_03FC, '0, '0);
    chk("lnt_kill", {31'd0, s_kill}, 32'd1);
    chk("lnt_pc_seq", bus.IF_PC, 32'h8000_0404);
    cycle(1, 0, 1, 0, 0, 1, 32'h8000_0400, '0, '0);
    chk("lnt_skip_pc", bus.IF_PC, 32'h8000_0408);

    // Exception beats a concurrent taken resolve, and beats WAIT_DS
    cycle(1, 1, 0, 1, 1, 1, 32'h8000_0404, 32'h8000_0800, 32'hBFC0_0380);
    chk("exc_pc", bus.IF_PC, 32'hBFC0_0380);
    chk("exc_flush", {31'd0, s_flush}, 32'd1);
    cycle(1, 1, 0, 0, 0, 0, 32'hBFC0_037C, 32'h8000_0900, '0);
    cycle(0, 0, 0, 0, 1, 1, '0, '0, 32'hBFC0_0380);
    chk("exc_ds_pc", bus.IF_PC, 32'hBFC0_0380);
    chk("exc_ds_busy", {31'd0, bus.Redirect_Busy}, 32'd0);

    // Async reset while in WAIT_DS
    cycle(1, 1, 0, 0, 0, 0, 32'hBFC0_037C, 32'h8000_0A00, '0);
    drive_idle();
    #2 resetn = 1'b0;
    #1;
    chk("arst_pc",    bus.IF_PC, 32'hBFC0_0000);
    chk("arst_busy",  {31'd0, bus.Redirect_Busy}, 32'd0);
    chk("arst_valid", {31'd0, bus.IF_Valid}, 32'd1);
    m_pc = RST_PC;
    pend_q.delete();
    @(negedge clk);
    resetn = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit rs, bf, df, dsf, exc, rdy;
      logic [31:0] etgt, xtgt;
      int kind;
      rs   = ($urandom_range(0, 3) == 0);
      kind = $urandom_range(0, 9);
      bf   = (kind < 5) || (kind == 9);
      df   = (kind >= 5);
      dsf  = $urandom_range(0, 1);
      exc  = ($urandom_range(0, 19) == 0);
      rdy  = ($urandom_range(0, 3) != 0);
      etgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      xtgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if (i % 500 == 7) etgt = 32'hFFFF_FFFC;
      cycle(rs, bf, df, dsf, exc, rdy, m_pc - 32'd4, etgt, xtgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
